// File: rtl/wide_add_seq_if.sv
// Request/response bundle for the multi-precision add/subtract sequencer.
// The master issues operands and start; the slave (the sequencer) returns status and the wide result.
interface wide_add_seq_if #(
  parameter int WORDS = 4
);
  logic                   start;
  logic                   sub;
  logic                   cin;
  logic [WORDS*32-1:0]    op_a;
  logic [WORDS*32-1:0]    op_b;
  logic                   busy;
  logic                   done;
  logic [WORDS*32-1:0]    result;
  logic                   cout;

  modport master (
    output start, sub, cin, op_a, op_b,
    input  busy, done, result, cout
  );

  modport slave (
    input  start, sub, cin, op_a, op_b,
    output busy, done, result, cout
  );
endinterface

// File: rtl/wide_add_seq.sv
// Multi-precision add/subtract sequencer: streams WORDS 32-bit limbs, LSW first, through one
// shared external 32-bit adder, chaining the carry between limbs and assembling the wide result.
module wide_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                resetn,
  wide_add_seq_if.slave       bus,
  output logic [31:0]         add_op1,
  output logic [31:0]         add_op2,
  output logic                add_cin,
  input  logic [31:0]         add_res,
  input  logic                add_cout
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [WORDS-1:0][31:0]   a_q, a_d;
  logic [WORDS-1:0][31:0]   b_q, b_d;
  logic [WORDS-1:0][31:0]   result_q, result_d;
  logic                     carry_q, carry_d;
  logic                     cout_q, cout_d;

  logic                     accept;
  logic                     last_limb;

  assign accept    = (state_q == IDLE) && bus.start;
  assign last_limb = (state_q == RUN) && (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_limb) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
    end
  end

  // Subtraction is folded in at acceptance: B is inverted and the +1 rides in on the carry.
  always_comb begin
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    if (accept) begin
      a_d     = bus.op_a;
      b_d     = bus.sub ? ~bus.op_b : bus.op_b;
      carry_d = bus.sub | bus.cin;
      idx_d   = '0;
    end else if (state_q == RUN) begin
      result_d[idx_q] = add_res;
      carry_d         = add_cout;
      if (last_limb) begin
        cout_d = add_cout;
        idx_d  = '0;
      end else begin
        idx_d  = idx_q + IDX_W'(1);
      end
    end
  end

  always_comb begin
    bus.busy   = (state_q == RUN) || (state_q == DONE);
    bus.done   = (state_q == DONE);
    bus.result = result_q;
    bus.cout   = cout_q;
    add_op1    = 32'd0;
    add_op2    = 32'd0;
    add_cin    = 1'b0;
    if (state_q == RUN) begin
      add_op1 = a_q[idx_q];
      add_op2 = b_q[idx_q];
      add_cin = carry_q;
    end
  end

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed and randomised checks of wide_add_seq with behavioural 32-bit adders attached,
// one instance with four limbs and one with a single limb.
module tb_wide_add_seq;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  wide_add_seq_if #(.WORDS(4)) bus4 ();
  wide_add_seq_if #(.WORDS(1)) bus1 ();

  logic [31:0] a4_op1, a4_op2, a4_res;
  logic        a4_cin, a4_cout;
  logic [31:0] a1_op1, a1_op2, a1_res;
  logic        a1_cin, a1_cout;

  // Reference adders standing in for the shared hardware adder.
  assign {a4_cout, a4_res} = {1'b0, a4_op1} + {1'b0, a4_op2} + {32'd0, a4_cin};
  assign {a1_cout, a1_res} = {1'b0, a1_op1} + {1'b0, a1_op2} + {32'd0, a1_cin};

  wide_add_seq #(.WORDS(4)) u_dut4 (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus4),
    .add_op1  (a4_op1),
    .add_op2  (a4_op2),
    .add_cin  (a4_cin),
    .add_res  (a4_res),
    .add_cout (a4_cout)
  );

  wide_add_seq #(.WORDS(1)) u_dut1 (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus1),
    .add_op1  (a1_op1),
    .add_op2  (a1_op2),
    .add_cin  (a1_cin),
    .add_res  (a1_res),
    .add_cout (a1_cout)
  );

  int num_checks = 0;
  int num_errors = 0;

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Called on a falling edge while the four-limb sequencer is idle; returns one falling edge
  // after the accepting rising edge, with start already dropped.
  task automatic applyStimulus(input logic [127:0] a, input logic [127:0] b, input logic s, input logic c);
    bus4.op_a  = a;
    bus4.op_b  = b;
    bus4.sub   = s;
    bus4.cin   = c;
    bus4.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus4.start = 1'b0;
  endtask

  // Counts falling edges (starting at 1 right after the start edge) until done; 0 means timeout.
  task automatic waitDone4(output int cycles, output int busy_cycles);
    cycles      = 0;
    busy_cycles = 0;
    for (int k = 1; k <= 20; k++) begin
      if (bus4.busy) busy_cycles++;
      if (bus4.done) begin
        cycles = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run4(input logic [127:0] a, input logic [127:0] b, input logic s, input logic c,
                      output logic [127:0] res, output logic co, output int cycles, output int busy_cycles);
    applyStimulus(a, b, s, c);
    waitDone4(cycles, busy_cycles);
    res = bus4.result;
    co  = bus4.cout;
    @(negedge clk);
  endtask

  logic [127:0] res;
  logic         co;
  int           cycles, busy_cycles, done_count;
  logic [127:0] ra, rb;
  logic         rs, rc;
  logic [128:0] model;

  initial begin
    resetn     = 1'b0;
    bus4.start = 1'b0; bus4.sub = 1'b0; bus4.cin = 1'b0; bus4.op_a = '0; bus4.op_b = '0;
    bus1.start = 1'b0; bus1.sub = 1'b0; bus1.cin = 1'b0; bus1.op_a = '0; bus1.op_b = '0;

    @(negedge clk);
    checkOutput("reset_busy",   128'(bus4.busy), 128'd0);
    checkOutput("reset_done",   128'(bus4.done), 128'd0);
    checkOutput("reset_result", bus4.result, 128'd0);
    checkOutput("reset_cout",   128'(bus4.cout), 128'd0);
    checkOutput("reset_adder",  128'({a4_op1, a4_op2, a4_cin}), 128'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // All-ones plus one ripples a carry through every limb.
    run4({128{1'b1}}, 128'd1, 1'b0, 1'b0, res, co, cycles, busy_cycles);
    checkOutput("t1_result",  res, 128'd0);
    checkOutput("t1_cout",    128'(co), 128'd1);
    checkOutput("t1_latency", 128'(cycles), 128'd5);
    checkOutput("t1_busy",    128'(busy_cycles), 128'd5);
    checkOutput("t1_idle_after", 128'(bus4.busy), 128'd0);

    run4(128'h1_FFFF_FFFF, 128'd0, 1'b0, 1'b1, res, co, cycles, busy_cycles);
    checkOutput("add_cin_result", res, 128'h2_0000_0000);
    checkOutput("add_cin_cout",   128'(co), 128'd0);

    // Subtraction; cin must be ignored in sub mode.
    run4(128'd5, 128'd7, 1'b1, 1'b1, res, co, cycles, busy_cycles);
    checkOutput("t2a_result", res, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE);
    checkOutput("t2a_cout",   128'(co), 128'd0);
    run4(128'd7, 128'd5, 1'b1, 1'b0, res, co, cycles, busy_cycles);
    checkOutput("t2b_result", res, 128'd2);
    checkOutput("t2b_cout",   128'(co), 128'd1);

    // Start held high through RUN and DONE with new operands must not disturb the running op.
    bus4.op_a = 128'd10; bus4.op_b = 128'd20; bus4.sub = 1'b0; bus4.cin = 1'b0; bus4.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus4.op_a = 128'd1000; bus4.op_b = 128'd2000;
    done_count = 0;
    for (int k = 1; k <= 20; k++) begin
      if (bus4.done) begin
        done_count++;
        break;
      end
      @(negedge clk);
    end
    checkOutput("t3_done_count", 128'(done_count), 128'd1);
    checkOutput("t3_result",     bus4.result, 128'd30);
    @(negedge clk);
    checkOutput("t3_ignored_busy", 128'(bus4.busy), 128'd0);
    checkOutput("t3_ignored_done", 128'(bus4.done), 128'd0);
    @(posedge clk);
    @(negedge clk);
    bus4.start = 1'b0;
    checkOutput("t3_accepted_busy", 128'(bus4.busy), 128'd1);
    waitDone4(cycles, busy_cycles);
    checkOutput("t3_second_latency", 128'(cycles), 128'd5);
    checkOutput("t3_second_result",  bus4.result, 128'd3000);
    @(negedge clk);

    // Reset pulse while limb 2 is on the adder.
    applyStimulus(128'h1111_2222_3333_4444_5555_6666_7777_8888, 128'h0101_0101_0101_0101_0101_0101_0101_0101, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    checkOutput("t4_busy",   128'(bus4.busy), 128'd0);
    checkOutput("t4_done",   128'(bus4.done), 128'd0);
    checkOutput("t4_result", bus4.result, 128'd0);
    @(negedge clk);
    resetn = 1'b1;
    done_count = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus4.done) done_count++;
      @(negedge clk);
    end
    checkOutput("t4_no_done", 128'(done_count), 128'd0);
    run4(128'd100, 128'd23, 1'b0, 1'b0, res, co, cycles, busy_cycles);
    checkOutput("t4_after_result",  res, 128'd123);
    checkOutput("t4_after_latency", 128'(cycles), 128'd5);

    // Single-limb instance: add with carry-in, then subtract with borrow.
    bus1.op_a = 32'hFFFF_FFFF; bus1.op_b = 32'd0; bus1.sub = 1'b0; bus1.cin = 1'b1; bus1.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.start = 1'b0;
    cycles = 0;
    for (int k = 1; k <= 10; k++) begin
      if (bus1.done) begin
        cycles = k;
        break;
      end
      @(negedge clk);
    end
    checkOutput("t5_latency", 128'(cycles), 128'd2);
    checkOutput("t5_result",  128'(bus1.result), 128'd0);
    checkOutput("t5_cout",    128'(bus1.cout), 128'd1);
    @(negedge clk);
    bus1.op_a = 32'd3; bus1.op_b = 32'd5; bus1.sub = 1'b1; bus1.cin = 1'b0; bus1.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.start = 1'b0;
    cycles = 0;
    for (int k = 1; k <= 10; k++) begin
      if (bus1.done) begin
        cycles = k;
        break;
      end
      @(negedge clk);
    end
    checkOutput("t5_sub_result", 128'(bus1.result), 128'hFFFF_FFFE);
    checkOutput("t5_sub_cout",   128'(bus1.cout), 128'd0);
    @(negedge clk);

    // Random operations against a 129-bit reference sum.
    for (int n = 0; n < 1000; n++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      model = {1'b0, ra} + {1'b0, (rs ? ~rb : rb)} + (rs ? 129'd1 : {128'd0, rc});
      checkOutput("t6_adder_idle", 128'({a4_op1, a4_op2, a4_cin}), 128'd0);
      applyStimulus(ra, rb, rs, rc);
      waitDone4(cycles, busy_cycles);
      checkOutput("t6_adder_done", 128'({a4_op1, a4_op2, a4_cin}), 128'd0);
      checkOutput("t6_result",     bus4.result, model[127:0]);
      checkOutput("t6_cout",       128'(bus4.cout), 128'(model[128]));
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
